fb_pingpong_ctrl: RTL and testbench

//  Double-buffer (ping-pong) controller for the 80x60 RGB565 camera frame store.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_rd_arbiter.sv | 88 ++++++++
 rtl/fb_pingpong_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fb_pingpong_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants for the ping-pong frame-buffer controller: frame geometry,
// FSM encodings, read-tag bit layout and the saturating counter helper.
package fb_pkg;

    localparam int FB_NB_ADDR  = 13;
    localparam int FB_IMG_PXLS = 4800;
    localparam int FB_NB_PXL   = 16;
    localparam int FB_NB_CNT   = 8;

    localparam logic [1:0] ST_WAIT_CFG = 2'd0;
    localparam logic [1:0] ST_SYNC     = 2'd1;
    localparam logic [1:0] ST_FILL     = 2'd2;
    localparam logic [1:0] ST_READY    = 2'd3;

    localparam int TAG_SEL   = 0;
    localparam int TAG_OLED  = 1;
    localparam int TAG_VGA   = 2;
    localparam int FB_NB_TAG = 3;

    function automatic logic [FB_NB_CNT-1:0] sat_inc(input logic [FB_NB_CNT-1:0] val);
        if (val == {FB_NB_CNT{1'b1}}) begin
            return val;
        end else begin
            return val + {{(FB_NB_CNT-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/fb_rd_arbiter.sv
// Front-buffer read port arbiter: VGA has fixed priority over OLED; request tags
// ride alongside the RAM latency and steer the returning word to its reader.
module fb_rd_arbiter
    import fb_pkg::*;
#(
    parameter int C_NB_ADDR = FB_NB_ADDR,
    parameter int C_NB_PXL  = FB_NB_PXL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 front,
    input  logic                 vga_rd,
    input  logic [C_NB_ADDR-1:0] vga_addr,
    input  logic                 oled_req,
    input  logic [C_NB_ADDR-1:0] oled_addr,
    input  logic [C_NB_PXL-1:0]  dout_a,
    input  logic [C_NB_PXL-1:0]  dout_b,
    output logic [C_NB_ADDR-1:0] rd_addr,
    output logic                 rd_sel,
    output logic                 oled_gnt,
    output logic                 vga_valid,
    output logic [C_NB_PXL-1:0]  vga_data,
    output logic                 oled_valid,
    output logic [C_NB_PXL-1:0]  oled_data
);

    logic [FB_NB_TAG-1:0] tag_nxt_s;
    logic [FB_NB_TAG-1:0] tag_r;
    logic [C_NB_PXL-1:0]  rd_data_s;
    logic                 vga_valid_r;
    logic                 oled_valid_r;
    logic [C_NB_PXL-1:0]  vga_data_r;
    logic [C_NB_PXL-1:0]  oled_data_r;

    // Fixed-priority address mux and request tag
    always_comb begin
        tag_nxt_s = {FB_NB_TAG{1'b0}};
        if (vga_rd) begin
            rd_addr  = vga_addr;
            oled_gnt = 1'b0;
        end else begin
            rd_addr  = oled_addr;
            oled_gnt = oled_req;
        end
        tag_nxt_s[TAG_VGA]  = vga_rd;
        tag_nxt_s[TAG_OLED] = oled_gnt;
        tag_nxt_s[TAG_SEL]  = front;
    end

    assign rd_sel = front;

    // Tag stage: remembers the buffer sampled in the request cycle so a swap
    // on that same edge still returns old-front data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r <= {FB_NB_TAG{1'b0}};
        end else begin
            tag_r <= tag_nxt_s;
        end
    end

    assign rd_data_s = tag_r[TAG_SEL] ? dout_b : dout_a;

    // Output registers; data holds between valid beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_valid_r  <= 1'b0;
            oled_valid_r <= 1'b0;
            vga_data_r   <= {C_NB_PXL{1'b0}};
            oled_data_r  <= {C_NB_PXL{1'b0}};
        end else begin
            vga_valid_r  <= tag_r[TAG_VGA];
            oled_valid_r <= tag_r[TAG_OLED];
            if (tag_r[TAG_VGA]) begin
                vga_data_r <= rd_data_s;
            end
            if (tag_r[TAG_OLED]) begin
                oled_data_r <= rd_data_s;
            end
        end
    end

    assign vga_valid  = vga_valid_r;
    assign oled_valid = oled_valid_r;
    assign vga_data   = vga_data_r;
    assign oled_data  = oled_data_r;

endmodule

// File: rtl/fb_pingpong_ctrl.sv
// Ping-pong frame-buffer controller: capture FSM, back-buffer write gating,
// tear-free swap on display frame start and drop/swap counters.
// Build option FB_FREEZE_EN adds a freeze input that holds the capture and blocks swaps.
module fb_pingpong_ctrl
    import fb_pkg::*;
#(
    parameter int C_NB_ADDR  = FB_NB_ADDR,
    parameter int C_IMG_PXLS = FB_IMG_PXLS,
    parameter int C_NB_PXL   = FB_NB_PXL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_done,
    input  logic                 cap_we,
    input  logic [C_NB_ADDR-1:0] cap_addr,
    input  logic                 disp_sof,
`ifdef FB_FREEZE_EN
    input  logic                 freeze,
`endif
    output logic                 wea_a,
    output logic                 wea_b,
    output logic                 front,
    output logic [C_NB_ADDR-1:0] rd_addr,
    output logic                 rd_sel,
    input  logic [C_NB_PXL-1:0]  dout_a,
    input  logic [C_NB_PXL-1:0]  dout_b,
    input  logic                 vga_rd,
    input  logic [C_NB_ADDR-1:0] vga_addr,
    output logic                 vga_valid,
    output logic [C_NB_PXL-1:0]  vga_data,
    input  logic                 oled_req,
    input  logic [C_NB_ADDR-1:0] oled_addr,
    output logic                 oled_gnt,
    output logic                 oled_valid,
    output logic [C_NB_PXL-1:0]  oled_data,
    output logic [FB_NB_CNT-1:0] drop_cnt,
    output logic [FB_NB_CNT-1:0] swap_cnt
);

    localparam logic [C_NB_ADDR-1:0] FIRST_ADDR = {C_NB_ADDR{1'b0}};
    localparam logic [C_NB_ADDR-1:0] LAST_ADDR  = C_NB_ADDR'(C_IMG_PXLS - 1);
    localparam logic [FB_NB_CNT-1:0] CNT_ONE    = {{(FB_NB_CNT-1){1'b0}}, 1'b1};

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic                 front_r;
    logic [FB_NB_CNT-1:0] drop_cnt_r;
    logic [FB_NB_CNT-1:0] swap_cnt_r;
    logic                 cap_sof_s;
    logic                 cap_eof_s;
    logic                 wr_en_s;
    logic                 drop_inc_s;
    logic                 swap_s;
    logic                 hold_s;
    logic                 release_s;

`ifdef FB_FREEZE_EN
    logic held_r;

    // Remembers that a freeze was active so its release can resynchronise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_r <= 1'b0;
        end else begin
            held_r <= cfg_done & freeze;
        end
    end

    assign hold_s    = freeze;
    assign release_s = held_r & ~freeze;
`else
    assign hold_s    = 1'b0;
    assign release_s = 1'b0;
`endif

    assign cap_sof_s = cap_we & (cap_addr == FIRST_ADDR);
    assign cap_eof_s = cap_we & (cap_addr == LAST_ADDR);

    // Capture FSM: only whole frames starting at address 0 reach the back buffer
    always_comb begin
        state_nxt_s = state_r;
        wr_en_s     = 1'b0;
        drop_inc_s  = 1'b0;
        swap_s      = 1'b0;
        if (!cfg_done) begin
            state_nxt_s = ST_WAIT_CFG;
        end else if (hold_s) begin
            state_nxt_s = state_r;
        end else if (release_s) begin
            state_nxt_s = ST_SYNC;
        end else begin
            case (state_r)
                ST_WAIT_CFG: begin
                    state_nxt_s = ST_SYNC;
                end
                ST_SYNC: begin
                    if (cap_sof_s) begin
                        wr_en_s     = 1'b1;
                        state_nxt_s = ST_FILL;
                    end else begin
                        state_nxt_s = ST_SYNC;
                    end
                end
                ST_FILL: begin
                    wr_en_s = cap_we;
                    if (cap_eof_s) begin
                        state_nxt_s = ST_READY;
                    end else if (cap_sof_s) begin
                        drop_inc_s  = 1'b1;
                        state_nxt_s = ST_FILL;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end
                ST_READY: begin
                    drop_inc_s = cap_sof_s;
                    if (disp_sof) begin
                        swap_s      = 1'b1;
                        state_nxt_s = ST_SYNC;
                    end else begin
                        state_nxt_s = ST_READY;
                    end
                end
                default: begin
                    state_nxt_s = ST_WAIT_CFG;
                end
            endcase
        end
    end

    // Back buffer is the one not on display; front never sees a write
    assign wea_a = wr_en_s & front_r;
    assign wea_b = wr_en_s & ~front_r;

    // FSM state, displayed-buffer flag and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_WAIT_CFG;
            front_r    <= 1'b0;
            drop_cnt_r <= {FB_NB_CNT{1'b0}};
            swap_cnt_r <= {FB_NB_CNT{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (swap_s) begin
                front_r    <= ~front_r;
                swap_cnt_r <= swap_cnt_r + CNT_ONE;
            end
            if (drop_inc_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    assign front    = front_r;
    assign drop_cnt = drop_cnt_r;
    assign swap_cnt = swap_cnt_r;

    fb_rd_arbiter #(
        .C_NB_ADDR (C_NB_ADDR),
        .C_NB_PXL  (C_NB_PXL)
    ) u_rd_arbiter (
        .clk        (clk),
        .rst_n      (rst_n),
        .front      (front_r),
        .vga_rd     (vga_rd),
        .vga_addr   (vga_addr),
        .oled_req   (oled_req),
        .oled_addr  (oled_addr),
        .dout_a     (dout_a),
        .dout_b     (dout_b),
        .rd_addr    (rd_addr),
        .rd_sel     (rd_sel),
        .oled_gnt   (oled_gnt),
        .vga_valid  (vga_valid),
        .vga_data   (vga_data),
        .oled_valid (oled_valid),
        .oled_data  (oled_data)
    );

endmodule

// File: tb/tb_fb_pingpong_ctrl.sv
// Randomised bench for fb_pingpong_ctrl: two behavioural RAMs and a frame-level
// reference model of capture, swap, drop counting and the read path.
module tb_fb_pingpong_ctrl;

    localparam int PX     = 4800;
    localparam int NCYC   = 45000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_done;
    logic        cap_we;
    logic [12:0] cap_addr;
    logic        disp_sof;
    logic        wea_a;
    logic        wea_b;
    logic        front;
    logic [12:0] rd_addr;
    logic        rd_sel;
    logic [15:0] dout_a;
    logic [15:0] dout_b;
    logic        vga_rd;
    logic [12:0] vga_addr;
    logic        vga_valid;
    logic [15:0] vga_data;
    logic        oled_req;
    logic [12:0] oled_addr;
    logic        oled_gnt;
    logic        oled_valid;
    logic [15:0] oled_data;
    logic [7:0]  drop_cnt;
    logic [7:0]  swap_cnt;
`ifdef FB_FREEZE_EN
    logic        freeze;
`endif
    logic [15:0] cap_data;

    logic [15:0] ram_a [0:8191];
    logic [15:0] ram_b [0:8191];
    logic [15:0] mdl_a [0:8191];
    logic [15:0] mdl_b [0:8191];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame-level view of the controller
    bit          m_cfg, m_armed, m_capt, m_full, m_held, m_front;
    int          m_drop, m_swap;
    bit          n_cfg, n_armed, n_capt, n_full, n_held, n_front;
    int          n_drop, n_swap;
    bit          e_wr, e_gnt;
    logic [12:0] e_rd_addr;
    logic [15:0] e_rd_val;
    bit          p1_v, p1_o;
    logic [15:0] p1_d;
    bit          e_vv, e_ov;
    logic [15:0] e_vd, e_od;

    fb_pingpong_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_done   (cfg_done),
        .cap_we     (cap_we),
        .cap_addr   (cap_addr),
        .disp_sof   (disp_sof),
`ifdef FB_FREEZE_EN
        .freeze     (freeze),
`endif
        .wea_a      (wea_a),
        .wea_b      (wea_b),
        .front      (front),
        .rd_addr    (rd_addr),
        .rd_sel     (rd_sel),
        .dout_a     (dout_a),
        .dout_b     (dout_b),
        .vga_rd     (vga_rd),
        .vga_addr   (vga_addr),
        .vga_valid  (vga_valid),
        .vga_data   (vga_data),
        .oled_req   (oled_req),
        .oled_addr  (oled_addr),
        .oled_gnt   (oled_gnt),
        .oled_valid (oled_valid),
        .oled_data  (oled_data),
        .drop_cnt   (drop_cnt),
        .swap_cnt   (swap_cnt)
    );

    always #5 clk = ~clk;

    // Two single-port style frame RAMs with one-cycle read latency
    always @(posedge clk) begin
        if (wea_a) ram_a[cap_addr] <= cap_data;
        if (wea_b) ram_b[cap_addr] <= cap_data;
        dout_a <= ram_a[rd_addr];
        dout_b <= ram_b[rd_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        cfg_done  = 1'b0;
        cap_we    = 1'b0;
        cap_addr  = 13'd0;
        cap_data  = 16'd0;
        disp_sof  = 1'b0;
        vga_rd    = 1'b0;
        vga_addr  = 13'd0;
        oled_req  = 1'b0;
        oled_addr = 13'd0;
`ifdef FB_FREEZE_EN
        freeze    = 1'b0;
`endif
    endtask

    task automatic model_reset();
        m_cfg = 0; m_armed = 0; m_capt = 0; m_full = 0; m_held = 0; m_front = 0;
        m_drop = 0; m_swap = 0;
        p1_v = 0; p1_o = 0; p1_d = 16'd0;
        e_vv = 0; e_ov = 0; e_vd = 16'd0; e_od = 16'd0;
    endtask

    task automatic check_reset();
        check_val("rst_wea_a", {31'd0, wea_a}, 32'd0);
        check_val("rst_wea_b", {31'd0, wea_b}, 32'd0);
        check_val("rst_front", {31'd0, front}, 32'd0);
        check_val("rst_gnt", {31'd0, oled_gnt}, 32'd0);
        check_val("rst_vvalid", {31'd0, vga_valid}, 32'd0);
        check_val("rst_ovalid", {31'd0, oled_valid}, 32'd0);
        check_val("rst_vdata", {16'd0, vga_data}, 32'd0);
        check_val("rst_odata", {16'd0, oled_data}, 32'd0);
        check_val("rst_drop", {24'd0, drop_cnt}, 32'd0);
        check_val("rst_swap", {24'd0, swap_cnt}, 32'd0);
    endtask

    // Decide what the controller must do this cycle from the frame rules
    task automatic model_eval();
        bit sof0, eof, frz, rel;
        sof0 = cap_we && (cap_addr == 13'd0);
        eof  = cap_we && (int'(cap_addr) == PX - 1);
        frz  = 0;
        rel  = 0;
`ifdef FB_FREEZE_EN
        frz = freeze;
        rel = m_held && !freeze;
`endif
        e_wr = 0;
        n_cfg = m_cfg; n_armed = m_armed; n_capt = m_capt; n_full = m_full;
        n_front = m_front; n_drop = m_drop; n_swap = m_swap;
        n_held = cfg_done && frz;
        if (!cfg_done) begin
            n_cfg = 0; n_armed = 0; n_capt = 0; n_full = 0;
        end else if (frz) begin
            n_cfg = m_cfg;
        end else if (rel || !m_cfg) begin
            n_cfg = 1; n_armed = 1; n_capt = 0; n_full = 0;
        end else if (m_armed) begin
            if (sof0) begin
                e_wr = 1; n_armed = 0; n_capt = 1;
            end
        end else if (m_capt) begin
            e_wr = cap_we;
            if (eof) begin
                n_capt = 0; n_full = 1;
            end else if (sof0 && m_drop < 255) begin
                n_drop = m_drop + 1;
            end
        end else if (m_full) begin
            if (sof0 && m_drop < 255) n_drop = m_drop + 1;
            if (disp_sof) begin
                n_front = !m_front; n_swap = (m_swap + 1) % 256;
                n_full = 0; n_armed = 1;
            end
        end
        e_gnt     = !vga_rd && oled_req;
        e_rd_addr = vga_rd ? vga_addr : oled_addr;
        e_rd_val  = m_front ? mdl_b[e_rd_addr] : mdl_a[e_rd_addr];
    endtask

    task automatic compare_all();
        check_val("wea_a", {31'd0, wea_a}, {31'd0, e_wr && m_front});
        check_val("wea_b", {31'd0, wea_b}, {31'd0, e_wr && !m_front});
        check_val("rd_addr", {19'd0, rd_addr}, {19'd0, e_rd_addr});
        check_val("rd_sel", {31'd0, rd_sel}, {31'd0, m_front});
        check_val("oled_gnt", {31'd0, oled_gnt}, {31'd0, e_gnt});
        check_val("front", {31'd0, front}, {31'd0, m_front});
        check_val("drop_cnt", {24'd0, drop_cnt}, 32'(m_drop));
        check_val("swap_cnt", {24'd0, swap_cnt}, 32'(m_swap));
        check_val("vga_valid", {31'd0, vga_valid}, {31'd0, e_vv});
        check_val("vga_data", {16'd0, vga_data}, {16'd0, e_vd});
        check_val("oled_valid", {31'd0, oled_valid}, {31'd0, e_ov});
        check_val("oled_data", {16'd0, oled_data}, {16'd0, e_od});
    endtask

    // Advance the model across the clock edge
    task automatic model_commit();
        e_vv = p1_v;
        e_ov = p1_o;
        if (p1_v) e_vd = p1_d;
        if (p1_o) e_od = p1_d;
        p1_v = vga_rd;
        p1_o = e_gnt;
        p1_d = e_rd_val;
        if (e_wr) begin
            if (m_front) mdl_a[cap_addr] = cap_data;
            else         mdl_b[cap_addr] = cap_data;
        end
        m_cfg = n_cfg; m_armed = n_armed; m_capt = n_capt; m_full = n_full;
        m_held = n_held; m_front = n_front; m_drop = n_drop; m_swap = n_swap;
    endtask

    initial begin
        int cap_ptr;
        cap_ptr = 0;
        for (int i = 0; i < 8192; i++) begin
            ram_a[i] = 16'd0; ram_b[i] = 16'd0;
            mdl_a[i] = 16'd0; mdl_b[i] = 16'd0;
        end
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset();
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            if (c == 20000) begin
                rst_n = 1'b0;
                drive_idle();
                #1;
                check_reset();
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            cfg_done = !(c < 40 || (c >= 9000 && c < 9006));
            if (c >= 30000 && c < 30300) begin
                cap_we   = 1'b1;
                cap_addr = 13'd0;
                cap_ptr  = 1;
            end else begin
                cap_we = ($urandom_range(0, 9) < 8);
                if (cap_we) begin
                    if ($urandom_range(0, 3999) == 0) cap_ptr = 0;
                    cap_addr = 13'(cap_ptr);
                    cap_ptr  = (cap_ptr + 1) % PX;
                end else begin
                    cap_addr = 13'($urandom_range(0, PX - 1));
                end
            end
            cap_data = 16'($urandom);
            disp_sof = (c % 2500 == 1250) || ($urandom_range(0, 2999) == 0) ||
                       (cap_we && int'(cap_addr) == PX - 1 && $urandom_range(0, 1) == 1);
            vga_rd    = 1'($urandom_range(0, 1));
            oled_req  = 1'($urandom_range(0, 1));
            vga_addr  = 13'($urandom_range(0, PX - 1));
            oled_addr = 13'($urandom_range(0, PX - 1));
`ifdef FB_FREEZE_EN
            freeze = (c >= 12000 && c < 17000);
`endif
            #1;
            model_eval();
            compare_all();
            model_commit();
            @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
